// File: rtl/io_input_ctrl.sv
// Memory-mapped KEY/SW input controller: synchronizers, optional debounce
// (enabled by IO_INPUT_DEBOUNCE_EN), ready/overrun flags with write-1-to-clear.
module io_input_ctrl #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
  parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrEn,
  input  logic [DBITS-1:0] wrData,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [DBITS-1:0] rdData,
  output logic             hit
);

  logic [3:0] r_key_s1, r_key_s2, r_key_deb;
  logic [9:0] r_sw_s1, r_sw_s2, r_sw_deb;
  logic [3:0] r_krdy, r_kovr;
  logic [9:0] r_srdy, r_sovr;

  logic [3:0] w_key_deb_nxt;
  logic [9:0] w_sw_deb_nxt;

`ifdef IO_INPUT_DEBOUNCE_EN
  logic [3:0]  r_key_cand, w_key_cand_nxt;
  logic [9:0]  r_sw_cand, w_sw_cand_nxt;
  logic [15:0] r_key_cnt, w_key_cnt_nxt;
  logic [15:0] r_sw_cnt, w_sw_cnt_nxt;
  logic [15:0] w_last;

  assign w_last = DEBOUNCE_CYCLES - 16'd1;

  // Debounced value loads on the same edge the counter reaches its last count.
  always_comb begin
    w_key_cand_nxt = r_key_cand;
    w_key_cnt_nxt  = r_key_cnt;
    w_key_deb_nxt  = r_key_deb;
    if (r_key_s2 != r_key_cand) begin
      w_key_cand_nxt = r_key_s2;
      w_key_cnt_nxt  = 16'd0;
    end else if (r_key_cnt != w_last) begin
      w_key_cnt_nxt = r_key_cnt + 16'd1;
      if (w_key_cnt_nxt == w_last) w_key_deb_nxt = r_key_cand;
    end else begin
      w_key_deb_nxt = r_key_cand;
    end

    w_sw_cand_nxt = r_sw_cand;
    w_sw_cnt_nxt  = r_sw_cnt;
    w_sw_deb_nxt  = r_sw_deb;
    if (r_sw_s2 != r_sw_cand) begin
      w_sw_cand_nxt = r_sw_s2;
      w_sw_cnt_nxt  = 16'd0;
    end else if (r_sw_cnt != w_last) begin
      w_sw_cnt_nxt = r_sw_cnt + 16'd1;
      if (w_sw_cnt_nxt == w_last) w_sw_deb_nxt = r_sw_cand;
    end else begin
      w_sw_deb_nxt = r_sw_cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_cand <= 4'hF;
      r_sw_cand  <= 10'h0;
      r_key_cnt  <= 16'd0;
      r_sw_cnt   <= 16'd0;
    end else begin
      r_key_cand <= w_key_cand_nxt;
      r_sw_cand  <= w_sw_cand_nxt;
      r_key_cnt  <= w_key_cnt_nxt;
      r_sw_cnt   <= w_sw_cnt_nxt;
    end
  end
`else
  assign w_key_deb_nxt = r_key_s2;
  assign w_sw_deb_nxt  = r_sw_s2;
`endif

  logic       w_kwr, w_swr;
  logic [3:0] w_kevt, w_krclr, w_koclr;
  logic [9:0] w_sevt, w_srclr, w_soclr;

  assign w_kwr   = wrEn && (addr == ADDR_KCTRL);
  assign w_swr   = wrEn && (addr == ADDR_SCTRL);
  assign w_krclr = w_kwr ? wrData[3:0]   : 4'h0;
  assign w_koclr = w_kwr ? wrData[11:8]  : 4'h0;
  assign w_srclr = w_swr ? wrData[9:0]   : 10'h0;
  assign w_soclr = w_swr ? wrData[29:20] : 10'h0;
  // KEY is active-low: a press is a debounced 1 -> 0 transition.
  assign w_kevt  = r_key_deb & ~w_key_deb_nxt;
  assign w_sevt  = r_sw_deb ^ w_sw_deb_nxt;

  // An event whose ready bit is being cleared this cycle re-arms ready, not overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_s1  <= 4'hF;
      r_key_s2  <= 4'hF;
      r_sw_s1   <= 10'h0;
      r_sw_s2   <= 10'h0;
      r_key_deb <= 4'hF;
      r_sw_deb  <= 10'h0;
      r_krdy    <= 4'h0;
      r_kovr    <= 4'h0;
      r_srdy    <= 10'h0;
      r_sovr    <= 10'h0;
    end else begin
      r_key_s1  <= KEY;
      r_key_s2  <= r_key_s1;
      r_sw_s1   <= SW;
      r_sw_s2   <= r_sw_s1;
      r_key_deb <= w_key_deb_nxt;
      r_sw_deb  <= w_sw_deb_nxt;
      r_krdy    <= (r_krdy & ~w_krclr) | w_kevt;
      r_kovr    <= (r_kovr & ~w_koclr) | (w_kevt & r_krdy & ~w_krclr);
      r_srdy    <= (r_srdy & ~w_srclr) | w_sevt;
      r_sovr    <= (r_sovr & ~w_soclr) | (w_sevt & r_srdy & ~w_srclr);
    end
  end

  always_comb begin
    rdData = '0;
    hit    = 1'b1;
    if (addr == ADDR_KEY)
      rdData = {{(DBITS-4){1'b0}}, ~r_key_deb};
    else if (addr == ADDR_SW)
      rdData = {{(DBITS-10){1'b0}}, r_sw_deb};
    else if (addr == ADDR_KCTRL)
      rdData = {{(DBITS-12){1'b0}}, r_kovr, 4'b0, r_krdy};
    else if (addr == ADDR_SCTRL)
      rdData = {{(DBITS-30){1'b0}}, r_sovr, 10'b0, r_srdy};
    else
      hit = 1'b0;
  end

endmodule
